// File: rtl/dw_deserializer.sv
// Narrow-to-wide packer: RATIO beats of INPUT_DW bits fill one OUTPUT_DW word; last_i flushes a partial word early.
// Build option DW_DESERIALIZER_ZERO_PAD_EN zeroes unfilled lanes of a presented word.
module dw_deserializer #(
  parameter int INPUT_DW  = 64,
  parameter int OUTPUT_DW = 512
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [INPUT_DW-1:0]                      data_i,
  input  logic                                     valid_i,
  input  logic                                     last_i,
  output logic                                     ready_o,
  output logic [OUTPUT_DW-1:0]                     data_o,
  output logic [OUTPUT_DW/INPUT_DW-1:0]            lane_valid_o,
  output logic                                     last_o,
  output logic                                     valid_o,
  input  logic                                     ready_i
);

  localparam int RATIO = OUTPUT_DW / INPUT_DW;
  localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  generate
    if (INPUT_DW < 1 || (OUTPUT_DW % INPUT_DW) != 0 || RATIO < 2) begin : g_bad_cfg
      $error("dw_deserializer: OUTPUT_DW must be an integer multiple (>=2) of INPUT_DW");
    end
  endgenerate

  typedef enum logic {
    S_FILL = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [OUTPUT_DW-1:0] r_data;
  logic [RATIO-1:0]     r_lane_valid;
  logic                 r_last;
  logic                 r_valid;

  logic [CNT_W-1:0]     w_lane;
  logic [OUTPUT_DW-1:0] w_wr_data;
  logic [OUTPUT_DW-1:0] w_pres_data;
  logic [RATIO-1:0]     w_wr_lv;
  logic                 w_close;

  assign ready_o = (r_state == S_FILL) ? 1'b1 : ready_i;

  // A beat taken during the output handshake always starts a fresh word in lane 0.
  assign w_lane  = (r_state == S_FILL) ? r_cnt : '0;
  assign w_close = last_i | ((r_state == S_FILL) & (r_cnt == LAST_LANE));

  always_comb begin
    w_wr_data = r_data;
    w_wr_lv   = (r_state == S_FILL) ? r_lane_valid : '0;
    for (int k = 0; k < RATIO; k++) begin
      if (w_lane == CNT_W'(k)) begin
        w_wr_data[k*INPUT_DW +: INPUT_DW] = data_i;
        w_wr_lv[k]                        = 1'b1;
      end
    end
  end

`ifdef DW_DESERIALIZER_ZERO_PAD_EN
  always_comb begin
    w_pres_data = w_wr_data;
    for (int k = 0; k < RATIO; k++) begin
      if (!w_wr_lv[k]) begin
        w_pres_data[k*INPUT_DW +: INPUT_DW] = '0;
      end
    end
  end
`else
  assign w_pres_data = w_wr_data;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_FILL;
      r_cnt        <= '0;
      r_data       <= '0;
      r_lane_valid <= '0;
      r_last       <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (valid_i) begin
            r_lane_valid <= w_wr_lv;
            if (w_close) begin
              r_state <= S_OUT;
              r_valid <= 1'b1;
              r_last  <= last_i;
              r_cnt   <= '0;
              r_data  <= w_pres_data;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_data <= w_wr_data;
            end
          end
        end
        S_OUT: begin
          if (ready_i) begin
            if (valid_i) begin
              r_lane_valid <= w_wr_lv;
              if (last_i) begin
                // Single-beat packet: present it immediately, staying in OUT.
                r_last <= 1'b1;
                r_cnt  <= '0;
                r_data <= w_pres_data;
              end else begin
                r_state <= S_FILL;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_cnt   <= CNT_W'(1);
                r_data  <= w_wr_data;
              end
            end else begin
              r_state      <= S_FILL;
              r_valid      <= 1'b0;
              r_last       <= 1'b0;
              r_lane_valid <= '0;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign data_o       = r_data;
  assign lane_valid_o = r_lane_valid;
  assign last_o       = r_last;
  assign valid_o      = r_valid;

endmodule

// File: tb/tb_dw_deserializer.sv
// Bench for dw_deserializer (64 -> 256, four lanes): directed cases plus randomized traffic against a queue scoreboard.
module tb_dw_deserializer;
  localparam int IDW = 64;
  localparam int ODW = 256;
  localparam int R   = ODW / IDW;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [IDW-1:0] data_i;
  logic           valid_i;
  logic           last_i;
  logic           ready_o;
  logic [ODW-1:0] data_o;
  logic [R-1:0]   lane_valid_o;
  logic           last_o;
  logic           valid_o;
  logic           ready_i;

  dw_deserializer #(.INPUT_DW(IDW), .OUTPUT_DW(ODW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .data_o(data_o), .lane_valid_o(lane_valid_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ODW-1:0] data;
    logic [R-1:0]   lv;
    logic           last;
    int             avail;
  } word_t;

  word_t          exp_q[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             cyc = 0;
  int             words_out = 0;
  int             rdy_low = 0;
  bit             rdy_watch = 0;
  bit             rand_rdy = 0;

  // Reference model: per-lane memory of the last beat written there, plus the lanes of the word being built.
  logic [IDW-1:0] m_lane[R];
  logic [R-1:0]   m_lv;
  int             m_cnt;
  word_t          m_w;

  logic           c_expv;
  bit             p_hold = 0;
  logic [ODW-1:0] p_data;
  logic [R-1:0]   p_lv;
  logic           p_last;
  word_t          c_w;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [ODW-1:0] act, input logic [ODW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < R; k++) m_lane[k] = '0;
    m_lv  = '0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // Input side: every accepted beat updates the model; a completed word becomes an expectation.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i && valid_i && ready_o) begin
      m_lane[m_cnt] = data_i;
      m_lv[m_cnt]   = 1'b1;
      m_cnt++;
      if (m_cnt == R || last_i) begin
        for (int k = 0; k < R; k++) begin
`ifdef DW_DESERIALIZER_ZERO_PAD_EN
          m_w.data[k*IDW +: IDW] = m_lv[k] ? m_lane[k] : '0;
`else
          m_w.data[k*IDW +: IDW] = m_lane[k];
`endif
        end
        m_w.lv    = m_lv;
        m_w.last  = last_i;
        m_w.avail = cyc + 1;
        exp_q.push_back(m_w);
        m_cnt = 0;
        m_lv  = '0;
      end
    end
  end

  // Output side: valid timing, ready rule, hold stability and word contents.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i) begin
      c_expv = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      check("valid_o", valid_o, c_expv);
      check("ready_o", ready_o, !valid_o || ready_i);
      if (rdy_watch && !ready_o) rdy_low++;
      if (p_hold && valid_o) begin
        check("hold_data", data_o, p_data);
        check("hold_lv", lane_valid_o, p_lv);
        check("hold_last", last_o, p_last);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h with no word expected", data_o);
        end else begin
          c_w = exp_q.pop_front();
          check("word_data", data_o, c_w.data);
          check("word_lv", lane_valid_o, c_w.lv);
          check("word_last", last_o, c_w.last);
          words_out++;
        end
      end
      p_hold = valid_o && !ready_i;
      p_data = data_o;
      p_lv   = lane_valid_o;
      p_last = last_o;
    end else begin
      p_hold = 0;
    end
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [IDW-1:0] d, input logic l);
    int g;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    g = 0;
    @(negedge clk_i);
    while (!ready_o && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: ready_o stayed %b, required 1", ready_o);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  logic [IDW-1:0] t2_beats[40];
  logic [ODW-1:0] exp_w;
  int             w0;
  int             g;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_last", last_o, 1'b0);
    check("rst_lv", lane_valid_o, '0);
    check("rst_data", data_o, '0);
    check("rst_ready", ready_o, 1'b1);
    rst_i = 1'b0;
    idle(1);

    // Basic full word
    send(64'h11, 0); send(64'h22, 0); send(64'h33, 0); send(64'h44, 0);
    exp_w = {64'h44, 64'h33, 64'h22, 64'h11};
    check("t1_valid", valid_o, 1'b1);
    check("t1_data", data_o, exp_w);
    check("t1_lv", lane_valid_o, 4'b1111);
    check("t1_last", last_o, 1'b0);
    idle(1);

    // Ten back-to-back words, no bubbles
    rdy_watch = 1;
    rdy_low = 0;
    w0 = words_out;
    for (int i = 0; i < 40; i++) begin
      t2_beats[i] = {$urandom, $urandom};
      send(t2_beats[i], 0);
    end
    idle(1);
    rdy_watch = 0;
    check("t2_words", words_out - w0, 10);
    check("t2_ready_low", rdy_low, 0);

    // Partial word flushed by last
    send(64'hA, 0); send(64'hB, 1);
    check("t3_lv", lane_valid_o, 4'b0011);
    check("t3_last", last_o, 1'b1);
    check("t3_lo", data_o[127:0], {64'hB, 64'hA});
`ifdef DW_DESERIALIZER_ZERO_PAD_EN
    check("t3_hi", data_o[255:128], '0);
`else
    check("t3_hi", data_o[255:128], {t2_beats[39], t2_beats[38]});
`endif
    idle(1);

    // Backpressure with a new beat waiting
    ready_i = 1'b0;
    send(64'hC1, 0); send(64'hC2, 0); send(64'hC3, 0); send(64'hC4, 0);
    exp_w = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
    valid_i = 1'b1; data_i = 64'h55; last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("t4_ready", ready_o, 1'b0);
      check("t4_data", data_o, exp_w);
    end
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    check("t4_lane0", data_o[63:0], 64'h55);
    check("t4_lv", lane_valid_o, 4'b0001);
    send(64'h56, 0); send(64'h57, 0); send(64'h58, 0);

    // Single-beat packet, taken during the previous word's handshake
    send(64'h77, 1);
    check("t5_lv", lane_valid_o, 4'b0001);
    check("t5_last", last_o, 1'b1);
    check("t5_lane0", data_o[63:0], 64'h77);
    idle(1);

    // Reset in the middle of a word
    send(64'h1, 0); send(64'h2, 0);
    rst_i = 1'b1;
    #1;
    check("t6_valid", valid_o, 1'b0);
    check("t6_last", last_o, 1'b0);
    check("t6_lv", lane_valid_o, '0);
    check("t6_data", data_o, '0);
    model_reset();
    idle(2);
    rst_i = 1'b0;
    idle(1);
    send(64'hD1, 0); send(64'hD2, 0); send(64'hD3, 0); send(64'hD4, 0);
    check("t6_word", data_o, {64'hD4, 64'hD3, 64'hD2, 64'hD1});
    idle(1);

    // Randomized traffic with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send({$urandom, $urandom}, $urandom_range(0, 4) == 0);
    end
    rand_rdy = 0;
    idle(1);
    ready_i = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      idle(1);
      g++;
    end
    check("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
